// File: rtl/bcd_convert_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_arbiter_if
// Brief    : Request/grant and result bus of the shared binary-to-BCD converter.
// Revision : 1.0
// ============================================================================
interface bcd_convert_arbiter_if;
  logic        req0;
  logic [7:0]  val0;
  logic        gnt0;
  logic        req1;
  logic [7:0]  val1;
  logic        gnt1;
  logic        busy;
  logic        done;
  logic        src;
  logic [11:0] bcd;
  logic [0:6]  HEX2;
  logic [0:6]  HEX1;
  logic [0:6]  HEX0;

  modport master (
    output req0, val0, req1, val1,
    input  gnt0, gnt1, busy, done, src, bcd, HEX2, HEX1, HEX0
  );

  modport slave (
    input  req0, val0, req1, val1,
    output gnt0, gnt1, busy, done, src, bcd, HEX2, HEX1, HEX0
  );
endinterface
`default_nettype wire

// File: rtl/bcd_convert_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_arbiter
// Brief    : Round-robin shared 8-bit binary to 3-digit BCD converter with
//            active-low 7-segment display drive.
// Revision : 1.0
// ============================================================================
module bcd_convert_arbiter #(
  parameter bit BLANK_ZEROS = 1'b1
) (
  input wire                    Clock,
  input wire                    Resetn,
  bcd_convert_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUND = 2'd1;
  localparam logic [1:0] S_TENS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] c_HUNDRED = 8'd100;
  localparam logic [7:0] c_TEN     = 8'd10;
  localparam logic [0:6] c_BLANK   = 7'b1111111;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_r;
  logic [1:0]  r_hcnt;
  logic [3:0]  r_tcnt;
  logic        r_last_gnt;
  logic [11:0] r_bcd;
  logic        r_src;

  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_busy;
  logic        w_done;
  logic        w_ge100;
  logic        w_ge10;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last_gnt);
  assign w_ge100 = (r_r >= c_HUNDRED);
  assign w_ge10  = (r_r >= c_TEN);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req0 | bus.req1) w_next = S_HUND;
      S_HUND: if (!w_ge100)            w_next = S_TENS;
      S_TENS: if (!w_ge10)             w_next = S_DONE;
      S_DONE:                          w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      w_gnt0 = bus.req0 & ~w_pick1;
      w_gnt1 = bus.req1 &  w_pick1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_r        <= 8'd0;
      r_hcnt     <= 2'd0;
      r_tcnt     <= 4'd0;
      r_last_gnt <= 1'b1;
      r_bcd      <= 12'h000;
      r_src      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_r        <= w_pick1 ? bus.val1 : bus.val0;
            r_hcnt     <= 2'd0;
            r_tcnt     <= 4'd0;
            r_last_gnt <= w_pick1;
          end
        end
        S_HUND: begin
          if (w_ge100) begin
            r_r    <= r_r - c_HUNDRED;
            r_hcnt <= r_hcnt + 2'd1;
          end
        end
        S_TENS: begin
          if (w_ge10) begin
            r_r    <= r_r - c_TEN;
            r_tcnt <= r_tcnt + 4'd1;
          end else begin
            r_bcd <= {2'b00, r_hcnt, r_tcnt, r_r[3:0]};
            r_src <= r_last_gnt;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [0:6] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b0000001;
      4'd1:    f_seg = 7'b1001111;
      4'd2:    f_seg = 7'b0010010;
      4'd3:    f_seg = 7'b0000110;
      4'd4:    f_seg = 7'b1001100;
      4'd5:    f_seg = 7'b0100100;
      4'd6:    f_seg = 7'b0100000;
      4'd7:    f_seg = 7'b0001111;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0000100;
      default: f_seg = c_BLANK;
    endcase
  endfunction

  logic w_blank2;
  logic w_blank1;

  // Tens is blanked only when hundreds is also zero, so interior zeros stay lit.
  assign w_blank2 = BLANK_ZEROS && (r_bcd[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);

  assign bus.HEX2 = w_blank2 ? c_BLANK : f_seg(r_bcd[11:8]);
  assign bus.HEX1 = w_blank1 ? c_BLANK : f_seg(r_bcd[7:4]);
  assign bus.HEX0 = f_seg(r_bcd[3:0]);

  assign bus.gnt0 = w_gnt0;
  assign bus.gnt1 = w_gnt1;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.src  = r_src;
  assign bus.bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_arbiter.sv
`default_nettype none
// Testbench for bcd_convert_arbiter: two instances (blanking on/off) share stimulus
// and are checked against an arithmetic model of the conversion and display.
module tb_bcd_convert_arbiter;

  logic Clock;
  logic Resetn;
  int   vectors;
  int   miscompares;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  bcd_convert_arbiter_if bi ();
  bcd_convert_arbiter_if bz ();

  assign bz.req0 = bi.req0;
  assign bz.val0 = bi.val0;
  assign bz.req1 = bi.req1;
  assign bz.val1 = bi.val1;

  bcd_convert_arbiter #(.BLANK_ZEROS(1'b1)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bi.slave)
  );

  bcd_convert_arbiter #(.BLANK_ZEROS(1'b0)) dutz (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bz.slave)
  );

  localparam logic [0:6] BLANK = 7'b1111111;

  function automatic logic [11:0] m_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int m_lat(input int v);
    return v / 100 + (v / 10) % 10 + 2;
  endfunction

  function automatic logic [0:6] m_seg(input int d);
    logic [0:6] t [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return t[d];
  endfunction

  function automatic logic [0:6] m_hex(input int v, input bit blank, input int pos);
    int h = v / 100;
    int t = (v / 10) % 10;
    int o = v % 10;
    if (pos == 2) return (blank && h == 0) ? BLANK : m_seg(h);
    if (pos == 1) return (blank && h == 0 && t == 0) ? BLANK : m_seg(t);
    return m_seg(o);
  endfunction

  // Requests one conversion, waits (bounded) for the grant, and counts edges to done.
  task automatic run_conv(input bit r, input logic [7:0] v, output bit ok, output int lat);
    int n;
    ok  = 1'b0;
    lat = -1;
    @(negedge Clock);
    if (r) begin bi.req1 = 1'b1; bi.val1 = v; end
    else   begin bi.req0 = 1'b1; bi.val0 = v; end
    n = 0;
    #1;
    while (n < 30 && !(r ? bi.gnt1 : bi.gnt0)) begin
      @(negedge Clock);
      #1;
      n++;
    end
    if (n >= 30) begin
      bi.req0 = 1'b0;
      bi.req1 = 1'b0;
      return;
    end
    @(posedge Clock);
    #1;
    if (r) bi.req1 = 1'b0; else bi.req0 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge Clock);
      lat++;
      @(negedge Clock);
      if (bi.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit   saw_done;
    logic ok;
    #1;
    vectors++; if ({bi.busy, bi.done, bi.src} !== 3'b000) begin miscompares++;
      $display("FAIL reset_ctl: got %b want 000", {bi.busy, bi.done, bi.src}); end
    vectors++; if (bi.bcd !== 12'h000) begin miscompares++;
      $display("FAIL reset_bcd: got %h want 000", bi.bcd); end
    vectors++; if ({bi.HEX2, bi.HEX1, bi.HEX0} !== {BLANK, BLANK, 7'b0000001}) begin miscompares++;
      $display("FAIL reset_hex: got %b want %b", {bi.HEX2, bi.HEX1, bi.HEX0}, {BLANK, BLANK, 7'b0000001}); end
    @(negedge Clock);
    Resetn = 1'b1;
    // reset during HUND of a 199 conversion
    @(negedge Clock);
    bi.req0 = 1'b1; bi.val0 = 8'd199;
    #1;
    ok = bi.gnt0;
    vectors++; if (ok !== 1'b1) begin miscompares++;
      $display("FAIL rst_mid_gnt0: got %b want 1", ok); end
    @(posedge Clock);
    #1 bi.req0 = 1'b0;
    @(posedge Clock);
    #2;
    vectors++; if (bi.busy !== 1'b1) begin miscompares++;
      $display("FAIL rst_mid_busy_before: got %b want 1", bi.busy); end
    Resetn = 1'b0;
    #1;
    vectors++; if ({bi.busy, bi.done, bi.bcd} !== 14'h0) begin miscompares++;
      $display("FAIL rst_mid_state: got busy=%b done=%b bcd=%h want 0 0 000", bi.busy, bi.done, bi.bcd); end
    vectors++; if ({bi.HEX2, bi.HEX1, bi.HEX0} !== {BLANK, BLANK, 7'b0000001}) begin miscompares++;
      $display("FAIL rst_mid_hex: got %b want %b", {bi.HEX2, bi.HEX1, bi.HEX0}, {BLANK, BLANK, 7'b0000001}); end
    vectors++; if ({bz.HEX2, bz.HEX1} !== {7'b0000001, 7'b0000001}) begin miscompares++;
      $display("FAIL rst_noblank_hex: got %b want %b", {bz.HEX2, bz.HEX1}, {7'b0000001, 7'b0000001}); end
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      if (bi.done !== 1'b0 || bi.busy !== 1'b0) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++;
      $display("FAIL rst_mid_no_done: got activity=%b want 0", saw_done); end
  endtask

  task automatic test_zero;
    bit ok; int lat;
    run_conv(1'b0, 8'd0, ok, lat);
    vectors++; if (ok !== 1'b1 || lat != 2) begin miscompares++;
      $display("FAIL zero_latency: got ok=%b lat=%0d want ok=1 lat=2", ok, lat); end
    vectors++; if ({bi.bcd, bi.src} !== {12'h000, 1'b0}) begin miscompares++;
      $display("FAIL zero_result: got bcd=%h src=%b want 000 0", bi.bcd, bi.src); end
    @(negedge Clock);
    vectors++; if (bi.done !== 1'b0) begin miscompares++;
      $display("FAIL zero_done_pulse: got %b want 0", bi.done); end
  endtask

  task automatic test_255;
    bit ok; int lat;
    run_conv(1'b1, 8'd255, ok, lat);
    vectors++; if (ok !== 1'b1 || lat != 9) begin miscompares++;
      $display("FAIL v255_latency: got ok=%b lat=%0d want ok=1 lat=9", ok, lat); end
    vectors++; if ({bi.bcd, bi.src} !== {12'h255, 1'b1}) begin miscompares++;
      $display("FAIL v255_result: got bcd=%h src=%b want 255 1", bi.bcd, bi.src); end
    vectors++; if ({bi.HEX2, bi.HEX1, bi.HEX0} !== {7'b0010010, 7'b0100100, 7'b0100100}) begin miscompares++;
      $display("FAIL v255_hex: got %b want %b", {bi.HEX2, bi.HEX1, bi.HEX0}, {7'b0010010, 7'b0100100, 7'b0100100}); end
  endtask

  task automatic test_busy_hold;
    bit early; int lat; bit seen;
    @(negedge Clock);
    bi.req0 = 1'b1; bi.val0 = 8'd199;
    #1;
    vectors++; if (bi.gnt0 !== 1'b1) begin miscompares++;
      $display("FAIL busy_gnt0: got %b want 1", bi.gnt0); end
    @(posedge Clock);
    #1;
    bi.req0 = 1'b0; bi.req1 = 1'b1; bi.val1 = 8'd42;
    early = 1'b0; seen = 1'b0; lat = 0;
    while (lat < 40) begin
      #1 if (bi.gnt1 !== 1'b0) early = 1'b1;
      @(posedge Clock);
      lat++;
      @(negedge Clock);
      #1 if (bi.gnt1 !== 1'b0) early = 1'b1;
      if (bi.done) begin seen = 1'b1; break; end
    end
    vectors++; if (seen !== 1'b1 || lat != 12) begin miscompares++;
      $display("FAIL v199_latency: got seen=%b lat=%0d want 1 12", seen, lat); end
    vectors++; if (bi.bcd !== 12'h199) begin miscompares++;
      $display("FAIL v199_bcd: got %h want 199", bi.bcd); end
    vectors++; if (early !== 1'b0) begin miscompares++;
      $display("FAIL busy_no_gnt1: got early=%b want 0", early); end
    @(negedge Clock);
    #1;
    vectors++; if (bi.gnt1 !== 1'b1) begin miscompares++;
      $display("FAIL busy_gnt1_after_done: got %b want 1", bi.gnt1); end
    @(posedge Clock);
    #1 bi.req1 = 1'b0;
    repeat (10) @(negedge Clock);
    vectors++; if ({bi.bcd, bi.src} !== {12'h042, 1'b1}) begin miscompares++;
      $display("FAIL busy_second_result: got bcd=%h src=%b want 042 1", bi.bcd, bi.src); end
  endtask

  task automatic test_tie;
    bit seen; int lat;
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    bi.req0 = 1'b1; bi.val0 = 8'd7; bi.req1 = 1'b1; bi.val1 = 8'd42;
    #1;
    vectors++; if ({bi.gnt0, bi.gnt1} !== 2'b10) begin miscompares++;
      $display("FAIL tie_first: got gnt0/1=%b want 10", {bi.gnt0, bi.gnt1}); end
    @(posedge Clock);
    #1 bi.req0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clock);
      if (bi.done) seen = 1'b1;
    end
    vectors++; if ({seen, bi.bcd, bi.src} !== {1'b1, 12'h007, 1'b0}) begin miscompares++;
      $display("FAIL tie_res0: got done=%b bcd=%h src=%b want 1 007 0", seen, bi.bcd, bi.src); end
    vectors++; if ({bi.HEX2, bi.HEX1, bi.HEX0} !== {BLANK, BLANK, 7'b0001111}) begin miscompares++;
      $display("FAIL tie_hex7: got %b want %b", {bi.HEX2, bi.HEX1, bi.HEX0}, {BLANK, BLANK, 7'b0001111}); end
    @(negedge Clock);
    #1;
    vectors++; if ({bi.gnt0, bi.gnt1} !== 2'b01) begin miscompares++;
      $display("FAIL tie_second: got gnt0/1=%b want 01", {bi.gnt0, bi.gnt1}); end
    @(posedge Clock);
    #1 bi.req1 = 1'b0;
    seen = 1'b0; lat = 0;
    while (lat < 20 && !seen) begin
      @(posedge Clock); lat++;
      @(negedge Clock);
      if (bi.done) seen = 1'b1;
    end
    vectors++; if ({seen, bi.bcd, bi.src} !== {1'b1, 12'h042, 1'b1} || lat != 6) begin miscompares++;
      $display("FAIL tie_res1: got done=%b bcd=%h src=%b lat=%0d want 1 042 1 6", seen, bi.bcd, bi.src, lat); end
    vectors++; if ({bi.HEX2, bi.HEX1} !== {BLANK, 7'b1001100}) begin miscompares++;
      $display("FAIL tie_hex42: got %b want %b", {bi.HEX2, bi.HEX1}, {BLANK, 7'b1001100}); end
    @(negedge Clock);
    bi.req0 = 1'b1; bi.req1 = 1'b1;
    #1;
    vectors++; if ({bi.gnt0, bi.gnt1} !== 2'b10) begin miscompares++;
      $display("FAIL tie_again: got gnt0/1=%b want 10", {bi.gnt0, bi.gnt1}); end
    bi.req0 = 1'b0; bi.req1 = 1'b0;
  endtask

  task automatic test_blank;
    bit ok; int lat;
    run_conv(1'b0, 8'd105, ok, lat);
    vectors++; if ({bi.HEX2, bi.HEX1, bi.HEX0} !== {7'b1001111, 7'b0000001, 7'b0100100}) begin miscompares++;
      $display("FAIL blank_105: got %b want %b", {bi.HEX2, bi.HEX1, bi.HEX0}, {7'b1001111, 7'b0000001, 7'b0100100}); end
    run_conv(1'b1, 8'd9, ok, lat);
    vectors++; if ({bz.HEX2, bz.HEX1, bz.HEX0} !== {7'b0000001, 7'b0000001, 7'b0000100}) begin miscompares++;
      $display("FAIL noblank_9: got %b want %b", {bz.HEX2, bz.HEX1, bz.HEX0}, {7'b0000001, 7'b0000001, 7'b0000100}); end
    vectors++; if ({bi.HEX2, bi.HEX1} !== {BLANK, BLANK}) begin miscompares++;
      $display("FAIL blank_9: got %b want %b", {bi.HEX2, bi.HEX1}, {BLANK, BLANK}); end
  endtask

  task automatic test_random;
    bit ok; int lat; int v; bit r;
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 255));
      r = 1'($urandom_range(0, 1));
      run_conv(r, 8'(v), ok, lat);
      vectors++; if (ok !== 1'b1 || lat != m_lat(v)) begin miscompares++;
        $display("FAIL rnd_latency v=%0d: got ok=%b lat=%0d want 1 %0d", v, ok, lat, m_lat(v)); end
      vectors++; if ({bi.bcd, bi.src} !== {m_bcd(v), r}) begin miscompares++;
        $display("FAIL rnd_result v=%0d: got bcd=%h src=%b want %h %b", v, bi.bcd, bi.src, m_bcd(v), r); end
      vectors++; if ({bi.HEX2, bi.HEX1, bi.HEX0} !== {m_hex(v, 1'b1, 2), m_hex(v, 1'b1, 1), m_hex(v, 1'b1, 0)}) begin
        miscompares++;
        $display("FAIL rnd_hex v=%0d: got %b want %b", v, {bi.HEX2, bi.HEX1, bi.HEX0},
                 {m_hex(v, 1'b1, 2), m_hex(v, 1'b1, 1), m_hex(v, 1'b1, 0)}); end
      vectors++; if ({bz.HEX2, bz.HEX1, bz.HEX0} !== {m_hex(v, 1'b0, 2), m_hex(v, 1'b0, 1), m_hex(v, 1'b0, 0)}) begin
        miscompares++;
        $display("FAIL rnd_hex_noblank v=%0d: got %b want %b", v, {bz.HEX2, bz.HEX1, bz.HEX0},
                 {m_hex(v, 1'b0, 2), m_hex(v, 1'b0, 1), m_hex(v, 1'b0, 0)}); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Resetn = 1'b0;
    bi.req0 = 1'b0; bi.val0 = 8'd0;
    bi.req1 = 1'b0; bi.val1 = 8'd0;
    #12;
    test_reset;
    test_zero;
    test_255;
    test_busy_hold;
    test_tie;
    test_blank;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
